// File: rtl/wb_bus_watchdog_pkg.sv
// Shared Wishbone encodings (CTI/BTE) and watchdog state encoding.
// Imported by the bus watchdog; keeps the encodings in one place for the integration layer.
package wb_bus_watchdog_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ABORT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ABORT = ST_ABORT,
    DRAIN = ST_DRAIN
  } wd_state_e;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Wishbone bus-cycle watchdog: zero-latency pass-through that aborts strobed accesses left
// unterminated for TIMEOUT cycles, returns one err beat to the master and records the fault.
module wb_bus_watchdog
  import wb_bus_watchdog_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int FCNT_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [31:0]       wbm_adr_i,
  input  logic [31:0]       wbm_dat_i,
  input  logic [3:0]        wbm_sel_i,
  input  logic              wbm_we_i,
  input  logic              wbm_cyc_i,
  input  logic              wbm_stb_i,
  input  logic [2:0]        wbm_cti_i,
  input  logic [1:0]        wbm_bte_i,
  output logic [31:0]       wbm_dat_o,
  output logic              wbm_ack_o,
  output logic              wbm_err_o,
  output logic              wbm_rty_o,
  output logic [31:0]       wbs_adr_o,
  output logic [31:0]       wbs_dat_o,
  output logic [3:0]        wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  input  logic [31:0]       wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i,
  input  logic              fault_clr_i,
  output logic              fault_valid_o,
  output logic [31:0]       fault_adr_o,
  output logic              fault_we_o,
  output logic [FCNT_W-1:0] fault_cnt_o,
  output logic              fault_irq_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  wd_state_e     state;
  logic [CW-1:0] wait_cnt;
  logic          term;
  logic          waiting;
  logic          expire;
  logic          pass;

  assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign waiting = wbm_cyc_i & wbm_stb_i & ~term;
  // A termination in the expiry cycle wins because waiting already excludes term.
  assign expire  = (state == IDLE) & waiting & (wait_cnt == WAIT_LAST);
  assign pass    = (state == IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      fault_valid_o <= 1'b0;
      fault_adr_o   <= '0;
      fault_we_o    <= 1'b0;
      fault_cnt_o   <= '0;
      fault_irq_o   <= 1'b0;
    end else begin
      fault_irq_o <= 1'b0;
      case (state)
        IDLE: begin
          if (expire) begin
            state       <= ABORT;
            fault_irq_o <= 1'b1;
          end
        end
        ABORT:   state <= DRAIN;
        DRAIN:   if (!wbm_cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (pass && waiting && !expire) wait_cnt <= wait_cnt + 1'b1;
      else                            wait_cnt <= '0;

      // A new fault overrides a coincident clear so it is never lost.
      if (expire) begin
        fault_valid_o <= 1'b1;
        fault_adr_o   <= wbm_adr_i;
        fault_we_o    <= wbm_we_i;
        if (fault_clr_i)       fault_cnt_o <= FCNT_W'(1);
        else if (!(&fault_cnt_o)) fault_cnt_o <= fault_cnt_o + 1'b1;
      end else if (fault_clr_i) begin
        fault_valid_o <= 1'b0;
        fault_cnt_o   <= '0;
      end
    end
  end

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_cti_o = wbm_cti_i;
  assign wbs_bte_o = wbm_bte_i;
  assign wbs_cyc_o = pass & wbm_cyc_i;
  assign wbs_stb_o = pass & wbm_stb_i;

  assign wbm_dat_o = pass ? wbs_dat_i : 32'h0;
  assign wbm_ack_o = pass & wbs_ack_i;
  assign wbm_err_o = pass ? wbs_err_i : (state == ABORT);
  assign wbm_rty_o = pass & wbs_rty_i;

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Self-checking bench for wb_bus_watchdog: vector table, directed corner cases and
// randomized traffic against a cycle-level behavioural model.
module tb_wb_bus_watchdog;

  localparam int TMO = 16;
  localparam int FW  = 8;
  localparam int CNT_MAX = (1 << FW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_dat_i, fault_adr_o;
  logic [3:0]  wbm_sel_i, wbs_sel_o;
  logic [2:0]  wbm_cti_i, wbs_cti_o;
  logic [1:0]  wbm_bte_i, wbs_bte_o;
  logic wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic fault_clr_i, fault_valid_o, fault_we_o, fault_irq_o;
  logic [FW-1:0] fault_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: phase 0 = forwarding, 1 = err beat, 2 = waiting for master release.
  int          m_phase;
  int          m_waited;
  logic        m_valid;
  logic [31:0] m_adr;
  logic        m_we;
  int          m_cnt;

  wb_bus_watchdog #(.TIMEOUT(TMO), .FCNT_W(FW)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .fault_clr_i(fault_clr_i), .fault_valid_o(fault_valid_o), .fault_adr_o(fault_adr_o),
    .fault_we_o(fault_we_o), .fault_cnt_o(fault_cnt_o), .fault_irq_o(fault_irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_valid = 1'b0; m_adr = '0; m_we = 1'b0; m_cnt = 0;
  endtask

  task automatic model_check();
    logic pa, ab;
    pa = (m_phase == 0);
    ab = (m_phase == 1);
    chk("wbs_cyc", wbs_cyc_o, pa & wbm_cyc_i);
    chk("wbs_stb", wbs_stb_o, pa & wbm_stb_i);
    chk("wbs_adr", wbs_adr_o, wbm_adr_i);
    chk("wbs_dat", wbs_dat_o, wbm_dat_i);
    chk("wbs_misc", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
        {wbm_sel_i, wbm_we_i, wbm_cti_i, wbm_bte_i});
    chk("wbm_ack", wbm_ack_o, pa & wbs_ack_i);
    chk("wbm_err", wbm_err_o, pa ? wbs_err_i : ab);
    chk("wbm_rty", wbm_rty_o, pa & wbs_rty_i);
    chk("wbm_dat", wbm_dat_o, pa ? wbs_dat_i : 32'h0);
    chk("fault_irq", fault_irq_o, ab);
    chk("fault_valid", fault_valid_o, m_valid);
    chk("fault_adr", fault_adr_o, m_adr);
    chk("fault_we", fault_we_o, m_we);
    chk("fault_cnt", fault_cnt_o, m_cnt);
  endtask

  task automatic model_update();
    logic silent, faulted;
    silent  = wbm_cyc_i & wbm_stb_i & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
    faulted = 1'b0;
    if (m_phase == 0) begin
      if (silent && m_waited == TMO - 1) begin
        faulted = 1'b1;
        m_phase = 1;
        m_waited = 0;
        m_valid = 1'b1;
        m_adr = wbm_adr_i;
        m_we = wbm_we_i;
        m_cnt = fault_clr_i ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      end else begin
        m_waited = silent ? m_waited + 1 : 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (!wbm_cyc_i) begin
      m_phase = 0;
    end
    if (!faulted && fault_clr_i) begin
      m_valid = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic finish_cycle();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #4;
    finish_cycle();
  endtask

  task automatic set_req(input logic cyc, input logic stb, input logic we, input logic [31:0] adr);
    wbm_cyc_i = cyc; wbm_stb_i = stb; wbm_we_i = we; wbm_adr_i = adr;
  endtask

  task automatic set_rsp(input logic ack, input logic err, input logic rty);
    wbs_ack_i = ack; wbs_err_i = err; wbs_rty_i = rty;
  endtask

  task automatic do_timeout(input logic [31:0] adr, input logic we);
    set_req(1'b1, 1'b1, we, adr);
    set_rsp(1'b0, 1'b0, 1'b0);
    repeat (TMO) step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
  endtask

  typedef struct {
    logic cyc, stb, we;
    logic [31:0] adr;
    logic ack, err, rty;
    logic x_ack, x_err, x_cyc;
  } vec_t;

  vec_t vt[8];

  initial begin
    #3_000_000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n_ack, n_err;
    vt[0] = '{1'b1, 1'b1, 1'b1, 32'h9000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'h9000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b1, 32'h9000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'h9000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    set_rsp(1'b0, 1'b0, 1'b0);
    wbm_dat_i = 32'hCAFE_0000; wbm_sel_i = 4'hF; wbm_cti_i = 3'b000; wbm_bte_i = 2'b00;
    wbs_dat_i = 32'h5A5A_0000; fault_clr_i = 1'b0;
    model_reset();
    #2;
    chk("reset_valid", fault_valid_o, 1'b0);
    chk("reset_cnt", fault_cnt_o, 8'd0);
    chk("reset_adr", fault_adr_o, 32'h0);
    chk("reset_irq", fault_irq_o, 1'b0);
    chk("reset_cyc_follow", wbs_cyc_o, 1'b1);
    chk("reset_adr_follow", wbs_adr_o, 32'h1234_5678);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    for (int i = 0; i < 8; i++) begin
      set_req(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].adr);
      set_rsp(vt[i].ack, vt[i].err, vt[i].rty);
      wbm_dat_i = 32'h1100_0000 + i;
      wbs_dat_i = 32'h2200_0000 + i;
      #4;
      chk("tbl_ack", wbm_ack_o, vt[i].x_ack);
      chk("tbl_err", wbm_err_o, vt[i].x_err);
      chk("tbl_cyc", wbs_cyc_o, vt[i].x_cyc);
      finish_cycle();
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    set_rsp(1'b0, 1'b0, 1'b0);
    step();
    chk("normal_no_fault", fault_valid_o, 1'b0);

    // Silent slave: err exactly in cycle TMO.
    set_req(1'b1, 1'b1, 1'b0, 32'hA000_0000);
    for (int c = 0; c < TMO; c++) begin
      #4;
      chk("to_wait_err", wbm_err_o, 1'b0);
      finish_cycle();
    end
    #4;
    chk("to_err", wbm_err_o, 1'b1);
    chk("to_slave_cyc", wbs_cyc_o, 1'b0);
    chk("to_irq", fault_irq_o, 1'b1);
    chk("to_adr", fault_adr_o, 32'hA000_0000);
    chk("to_cnt", fault_cnt_o, 8'd1);
    finish_cycle();
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    #4;
    chk("to_err_once", wbm_err_o, 1'b0);
    chk("to_irq_once", fault_irq_o, 1'b0);
    finish_cycle();

    // Ack in the last allowed cycle completes normally.
    set_req(1'b1, 1'b1, 1'b1, 32'hA000_0010);
    repeat (TMO - 1) step();
    set_rsp(1'b1, 1'b0, 1'b0);
    #4;
    chk("bnd_ack", wbm_ack_o, 1'b1);
    finish_cycle();
    set_rsp(1'b0, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    #4;
    chk("bnd_no_err", wbm_err_o, 1'b0);
    chk("bnd_cnt", fault_cnt_o, 8'd1);
    finish_cycle();

    // Late ack during the err beat is swallowed.
    set_req(1'b1, 1'b1, 1'b0, 32'hA000_0020);
    repeat (TMO) step();
    set_rsp(1'b1, 1'b0, 1'b0);
    #4;
    chk("late_ack_hidden", wbm_ack_o, 1'b0);
    chk("late_err", wbm_err_o, 1'b1);
    finish_cycle();
    set_rsp(1'b0, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // 4-beat incrementing burst, each beat acked after 10 wait cycles.
    n_ack = 0; n_err = 0;
    for (int b = 0; b < 4; b++) begin
      set_req(1'b1, 1'b1, 1'b0, 32'h8000_0000 + 32'(b * 4));
      wbm_cti_i = (b == 3) ? 3'b111 : 3'b010;
      wbm_bte_i = 2'b00;
      for (int c = 0; c <= 10; c++) begin
        set_rsp(c == 10, 1'b0, 1'b0);
        #4;
        n_ack += int'(wbm_ack_o);
        n_err += int'(wbm_err_o);
        finish_cycle();
      end
    end
    set_rsp(1'b0, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    wbm_cti_i = 3'b000;
    step();
    chk("burst_acks", n_ack, 4);
    chk("burst_errs", n_err, 0);

    // Master keeps cyc for 5 cycles after err; slave must stay isolated.
    set_req(1'b1, 1'b1, 1'b1, 32'hA000_0030);
    repeat (TMO + 1) step();
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("drain_slave_cyc", wbs_cyc_o, 1'b0);
      finish_cycle();
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    set_req(1'b1, 1'b1, 1'b0, 32'h4000_0000);
    #4;
    chk("drain_released", wbs_cyc_o, 1'b1);
    finish_cycle();
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // Saturation after a clear.
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    chk("clr_cnt", fault_cnt_o, 8'd0);
    for (int k = 0; k < 300; k++) do_timeout(32'hC000_0000 + 32'(k), k[0]);
    chk("sat_cnt", fault_cnt_o, 8'd255);

    // Clear on the same edge as a new fault: fault wins.
    set_req(1'b1, 1'b1, 1'b1, 32'hD000_0000);
    repeat (TMO - 1) step();
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    #4;
    chk("coinc_cnt", fault_cnt_o, 8'd1);
    chk("coinc_valid", fault_valid_o, 1'b1);
    chk("coinc_adr", fault_adr_o, 32'hD000_0000);
    finish_cycle();
    step();

    // Asynchronous reset during a wait.
    set_req(1'b1, 1'b1, 1'b1, 32'hB000_0000);
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", fault_valid_o, 1'b0);
    chk("arst_cnt", fault_cnt_o, 8'd0);
    chk("arst_adr", fault_adr_o, 32'h0);
    chk("arst_we", fault_we_o, 1'b0);
    chk("arst_cyc_follow", wbs_cyc_o, 1'b1);
    chk("arst_err", wbm_err_o, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (TMO - 1) step();
    set_rsp(1'b1, 1'b0, 1'b0);
    #4;
    chk("arst_after_ack", wbm_ack_o, 1'b1);
    chk("arst_after_err", wbm_err_o, 1'b0);
    finish_cycle();
    set_rsp(1'b0, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    for (int r = 0; r < 3000; r++) begin
      wbm_cyc_i   = ($urandom_range(7) != 0);
      wbm_stb_i   = wbm_cyc_i & ($urandom_range(3) != 0);
      wbm_we_i    = $urandom_range(1) == 1;
      wbm_adr_i   = $urandom;
      wbm_dat_i   = $urandom;
      wbm_sel_i   = 4'($urandom_range(15));
      wbm_cti_i   = 3'($urandom_range(7));
      wbm_bte_i   = 2'($urandom_range(3));
      wbs_dat_i   = $urandom;
      wbs_ack_i   = ($urandom_range(11) == 0);
      wbs_err_i   = ($urandom_range(39) == 0);
      wbs_rty_i   = ($urandom_range(39) == 0);
      fault_clr_i = ($urandom_range(49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_bus_watchdog.md
# wb_bus_watchdog

Wishbone bus-cycle watchdog inserted between a CPU or debug master port and the wishbone interconnect's master-side input. Forwards every transaction unchanged with zero added latency. If the addressed slave gives no ack/err/rty within TIMEOUT cycles, it aborts the cycle toward the slave, returns a one-cycle err to the master and latches the faulting address. This keeps accesses to unmapped or hung peripherals from locking up the or1k data bus.

## Interface
- TIMEOUT, 255, cycles a strobed access may wait for termination; legal range 2..65535
- FCNT_W, 8, width of saturating fault counter
- wb_clk_i  in  1  bus clock
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  32/32/4/1/1/1/3/2  request from master
- wbm_dat_o/ack_o/err_o/rty_o  out  32/1/1/1  response to master
- wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  32/32/4/1/1/1/3/2  request to interconnect
- wbs_dat_i/ack_i/err_i/rty_i  in  32/1/1/1  response from interconnect
- fault_clr_i  in  1  synchronous clear of fault status
- fault_valid_o  out  1  sticky: at least one timeout since clear
- fault_adr_o  out  32  address of most recent timed-out access
- fault_we_o  out  1  we of most recent timed-out access
- fault_cnt_o  out  FCNT_W  saturating timeout count
- fault_irq_o  out  1  one-cycle pulse per timeout

## Operation
- States: IDLE, ABORT, DRAIN. Reset state IDLE.
- IDLE: all wbs_* request outputs = wbm_* inputs; wbm_dat/ack/err/rty_o = wbs_* inputs (combinational).
- Wait counter, reset 0, width clog2(TIMEOUT):
  - term = wbs_ack_i | wbs_err_i | wbs_rty_i.
  - In IDLE with cyc&stb&!term: increment.
  - Otherwise (term, stb low, or not IDLE): clear to 0.
- IDLE → ABORT when cyc&stb&!term and counter == TIMEOUT-1.
- ABORT (exactly one cycle):
  - wbs_cyc_o = wbs_stb_o = 0.
  - wbm_err_o = 1; wbm_ack_o = wbm_rty_o = 0; wbm_dat_o = 0.
  - Late slave response is discarded.
  - fault_adr_o/fault_we_o load from wbm_* (registered at the transition edge); fault_valid_o set; fault_cnt_o += 1, saturating at all-ones.
  - fault_irq_o = 1.
  - Next state DRAIN.
- DRAIN:
  - wbs_cyc_o = wbs_stb_o = 0; all wbm responses 0.
  - Stays until wbm_cyc_i == 0, then IDLE. A master that keeps cyc high after err never reaches the slave again in that cycle.
- fault_clr_i: clears fault_valid_o and fault_cnt_o. If it coincides with the ABORT-entry edge, the new fault wins: valid = 1, cnt = 1, adr updated.

## Timing
- Pass-through latency 0 cycles, request and response.
- stb first high at cycle 0 with no term through cycle TIMEOUT-1 → wbm_err_o high in cycle TIMEOUT, for one cycle.
- Term in cycle TIMEOUT-1 or earlier → normal completion, no abort; term and expiry in the same cycle resolve to term.
- Multi-beat bursts: counter clears on every term, so each beat gets its own TIMEOUT budget.
- Reset values:
  - All wbs_* request outputs follow wbm_* inputs (state IDLE).
  - fault_valid_o = 0, fault_adr_o = 0, fault_we_o = 0, fault_cnt_o = 0, fault_irq_o = 0, counter = 0.
- Reset asserted mid-cycle: immediate return to IDLE and reset values; no err is generated.

## Structure
- Shared Wishbone package/include: CTI/BTE encodings and the state encoding localparams (IDLE = 2'd0, ABORT = 2'd1, DRAIN = 2'd2).
- Single module. The saturating fault counter is simple enough to stay inline; no sub-module.
- Integrated by the top level between the master port and the interconnect, one instance per guarded master.

## Test plan
- Normal access: write to 0x90000000, slave acks at cycle 3 → ack forwarded in cycle 3, err never high, fault_valid_o = 0.
- Timeout: TIMEOUT = 16, read 0xA0000000, slave silent → err in cycle 16 only; wbs_cyc_o low from cycle 16; fault_adr_o = 0xA0000000, fault_cnt_o = 1, one irq pulse.
- Boundary: TIMEOUT = 16, ack in cycle 15 → ack forwarded, no err; ack arriving during ABORT → not forwarded to master.
- Burst: 4-beat incrementing burst (cti 010 → 111), each beat acked after 10 cycles with TIMEOUT = 16 → no abort.
- Drain/saturation: master holds cyc 5 cycles after err → slave cyc stays 0 until release; 300 timeouts with FCNT_W = 8 → fault_cnt_o = 255; clear coinciding with a fault → cnt = 1.
- Async reset asserted during wait at cycle 8 → outputs at reset values immediately; after release, a new access is forwarded normally.
